// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings, data-phase FSM states and lane helpers for the instruction/data
// memory subordinate.
package ahb_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HSIZE_BYTE = 3'd0;
    localparam logic [2:0] HSIZE_HALF = 3'd1;
    localparam logic [2:0] HSIZE_WORD = 3'd2;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    typedef enum logic [2:0] {
        StIdle,
        StWait,
        StData,
        StErr1,
        StErr2
    } ahb_state_e;

    function automatic logic [3:0] ahb_byte_en(input logic [2:0] size, input logic [1:0] addr_lo);
        logic [3:0] be;
        be = 4'h0;
        case (size)
            HSIZE_BYTE: be = 4'b0001 << addr_lo;
            HSIZE_HALF: be = addr_lo[1] ? 4'b1100 : 4'b0011;
            HSIZE_WORD: be = 4'hF;
            default:    be = 4'h0;
        endcase
        return be;
    endfunction

    function automatic logic ahb_misaligned(input logic [2:0] size, input logic [1:0] addr_lo);
        return ((size == HSIZE_HALF) && addr_lo[0]) ||
               ((size == HSIZE_WORD) && (addr_lo != 2'b00));
    endfunction

endpackage

// File: rtl/ahb_sram_array.sv
// Synchronous 32-bit SRAM with per-byte write enables and a registered read port.
// Contents are never reset; the read register only updates when a read is requested.
module ahb_sram_array #(
    parameter int unsigned WORDS = 1024
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [3:0]               be,
    input  logic [$clog2(WORDS)-1:0] waddr,
    input  logic [31:0]              wdata,
    input  logic                     re,
    input  logic [$clog2(WORDS)-1:0] raddr,
    output logic [31:0]              rdata
);

    logic [31:0] mem [WORDS];

    // A read and a write to the same word on one edge returns the old word; the
    // caller merges the new lanes itself.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) begin
                    mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/ahb_imem_slave.sv
// AHB-Lite subordinate in front of the on-chip instruction/data SRAM: address-phase capture,
// wait-state insertion, two-cycle ERROR responses, byte-lane writes and write-to-read bypass.
module ahb_imem_slave
    import ahb_pkg::*;
#(
    parameter int unsigned MEM_WORDS   = 1024,
    parameter int unsigned WAIT_STATES = 0,
    parameter logic [31:0] BASE_ADDR   = 32'h0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        HSEL,
    input  logic [31:0] HADDR,
    input  logic [1:0]  HTRANS,
    input  logic        HWRITE,
    input  logic [2:0]  HSIZE,
    input  logic [31:0] HWDATA,
    input  logic        HREADY,
    output logic        HREADYOUT,
    output logic [31:0] HRDATA,
    output logic        HRESP
);

    localparam int unsigned AW        = $clog2(MEM_WORDS);
    localparam logic [31:0] MEM_BYTES = 32'(MEM_WORDS * 4);
    localparam logic [2:0]  WS        = 3'(WAIT_STATES);

    ahb_state_e    state_q, state_d;
    logic [2:0]    cnt_q, cnt_d;
    logic [AW-1:0] addr_q;
    logic          wr_q;
    logic [3:0]    be_q;
    logic [3:0]    byp_be_q;
    logic [31:0]   byp_data_q;
    logic [31:0]   hrdata_q;

    logic [31:0]   offset;
    logic [AW-1:0] req_idx;
    logic          xfer_err;
    logic          accept;
    logic          ready;
    logic          resp;
    logic          wr_done;
    logic          rd_done;
    logic [31:0]   sram_rdata;
    logic [31:0]   rdata_merged;
    logic          unused_htrans;

    assign unused_htrans = HTRANS[0];

    assign offset   = HADDR - BASE_ADDR;
    assign req_idx  = offset[AW+1:2];
    assign xfer_err = (HSIZE > HSIZE_WORD) || ahb_misaligned(HSIZE, HADDR[1:0]) ||
                      (offset >= MEM_BYTES);

    // Own ready gates the accept so a stray HTRANS while we stall is ignored.
    assign accept  = HSEL && HREADY && HTRANS[1] && ready;
    assign wr_done = (state_q == StData) && wr_q;
    assign rd_done = (state_q == StData) && !wr_q;

    always_comb begin
        ready = 1'b1;
        resp  = HRESP_OKAY;
        case (state_q)
            StWait: ready = 1'b0;
            StErr1: begin
                ready = 1'b0;
                resp  = HRESP_ERROR;
            end
            StErr2:  resp = HRESP_ERROR;
            default: ;
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            StWait: begin
                if (cnt_q == WS) begin
                    state_d = StData;
                    cnt_d   = 3'd0;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            StErr1: state_d = StErr2;
            default: begin
                // Idle, Data and Err2 all present HREADYOUT=1 and may take a new transfer.
                state_d = StIdle;
                if (accept) begin
                    if (xfer_err) begin
                        state_d = StErr1;
                    end else if (WS != 3'd0) begin
                        state_d = StWait;
                        cnt_d   = 3'd1;
                    end else begin
                        state_d = StData;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= StIdle;
            cnt_q      <= 3'd0;
            addr_q     <= '0;
            wr_q       <= 1'b0;
            be_q       <= 4'h0;
            byp_be_q   <= 4'h0;
            byp_data_q <= 32'h0;
            hrdata_q   <= 32'h0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (rd_done) begin
                hrdata_q <= rdata_merged;
            end
            if (accept) begin
                addr_q     <= req_idx;
                wr_q       <= HWRITE;
                be_q       <= ahb_byte_en(HSIZE, HADDR[1:0]);
                // Write retiring on the edge that accepts a read of the same word.
                byp_be_q   <= (wr_done && (addr_q == req_idx)) ? be_q : 4'h0;
                byp_data_q <= HWDATA;
            end
        end
    end

    ahb_sram_array #(
        .WORDS (MEM_WORDS)
    ) u_sram (
        .clk   (clk),
        .we    (wr_done),
        .be    (be_q),
        .waddr (addr_q),
        .wdata (HWDATA),
        .re    (accept && !HWRITE && !xfer_err),
        .raddr (req_idx),
        .rdata (sram_rdata)
    );

    always_comb begin
        rdata_merged = sram_rdata;
        for (int i = 0; i < 4; i++) begin
            if (byp_be_q[i]) begin
                rdata_merged[8*i +: 8] = byp_data_q[8*i +: 8];
            end
        end
    end

    assign HREADYOUT = ready;
    assign HRESP     = resp;
    assign HRDATA    = rd_done ? rdata_merged : hrdata_q;

endmodule
